// File: rtl/ps2_rx_pkg.sv
// rtl/ps2_rx_pkg.sv - shared types and PS/2 constants for the framed PS/2 receiver
package ps2_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_t;

    localparam int unsigned PS2_DATA_BITS      = 8;
    localparam int unsigned PS2_ODD_PARITY     = 1;
    localparam int unsigned PS2_TIMEOUT_CYCLES = 100000;  // 2 ms at 50 MHz

    // Counter width that never collapses to zero bits.
    function automatic int unsigned clog2_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - synchronous first-word-fall-through FIFO for received bytes
module ps2_rx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[head];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + AW'(1);
            if (do_pop)  head <= head + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[tail] <= push_data;
    end

endmodule

// File: rtl/ps2_rx_framed.sv
// rtl/ps2_rx_framed.sv - PS/2 device-to-host frame receiver with parity/stop/timeout checks
module ps2_rx_framed
    import ps2_rx_pkg::*;
#(
    parameter int unsigned DATA_BITS      = PS2_DATA_BITS,
    parameter int unsigned PARITY_EN      = 1,
    parameter int unsigned ODD_PARITY     = PS2_ODD_PARITY,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wait_for_incoming_data,
    input  logic                          start_receiving_data,
    input  logic                          ps2_clk_posedge,
    input  logic                          ps2_clk_negedge,
    input  logic                          ps2_data,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          timeout_err,
    output logic                          overflow
);

    localparam int unsigned BCW = clog2_w(DATA_BITS);
    localparam int unsigned TCW = clog2_w(TIMEOUT_CYCLES);

    ps2_state_t         state, state_nxt;
    logic [BCW-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS:0] shift_in;
    logic               parity_ok;
    logic [TCW-1:0]     to_cnt;
    logic               any_edge;
    logic               timeout_hit;
    logic               last_bit;
    logic               stop_done;
    logic               push_req;
    logic               push_accept;
    logic               fifo_full;
    logic               fifo_empty;

    assign any_edge    = ps2_clk_posedge | ps2_clk_negedge;
    assign timeout_hit = busy && !any_edge && (to_cnt == TCW'(TIMEOUT_CYCLES - 1));
    assign last_bit    = (bit_cnt == BCW'(DATA_BITS - 1));
    assign shift_in    = {ps2_data, shift_reg};
    assign push_accept = !fifo_full || rd_en;
    assign rd_valid    = !fifo_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (wait_for_incoming_data)    state_nxt = ST_WAIT_START;
                else if (start_receiving_data) state_nxt = ST_DATA;
            end
            ST_WAIT_START: begin
                if (ps2_clk_posedge && !ps2_data) state_nxt = ST_DATA;
                else if (!wait_for_incoming_data) state_nxt = ST_IDLE;
            end
            ST_DATA: begin
                if (timeout_hit) state_nxt = ST_IDLE;
                else if (ps2_clk_posedge && last_bit)
                    state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (timeout_hit)          state_nxt = ST_IDLE;
                else if (ps2_clk_posedge) state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (timeout_hit || ps2_clk_posedge) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == ST_DATA) || (state == ST_PARITY) || (state == ST_STOP);
        stop_done = (state == ST_STOP) && ps2_clk_posedge;
        push_req  = stop_done && parity_ok && ps2_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            parity_ok <= 1'b1;
            to_cnt    <= '0;
        end else begin
            if (state != ST_DATA)     bit_cnt <= '0;
            else if (ps2_clk_posedge) bit_cnt <= bit_cnt + BCW'(1);

            // LSB arrives first, so new bits enter at the top and move down.
            if (state == ST_DATA && ps2_clk_posedge) shift_reg <= shift_in[DATA_BITS:1];

            if (state == ST_PARITY) begin
                if (ps2_clk_posedge)
                    parity_ok <= (((^shift_reg) ^ ps2_data) == (ODD_PARITY != 0));
            end else if (state != ST_STOP) begin
                parity_ok <= 1'b1;
            end

            if (!busy || any_edge) to_cnt <= '0;
            else                   to_cnt <= to_cnt + TCW'(1);
        end
    end

    // Error checks are prioritised so each frame yields at most one pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            parity_err  <= stop_done && !parity_ok;
            frame_err   <= stop_done && parity_ok && !ps2_data;
            timeout_err <= timeout_hit;
            overflow    <= push_req && !push_accept;
        end
    end

    ps2_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req),
        .push_data (shift_reg),
        .pop       (rd_en),
        .pop_data  (rd_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_ps2_rx_framed.sv
// tb/tb_ps2_rx_framed.sv - directed self-checking bench for ps2_rx_framed
module tb_ps2_rx_framed;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       wait1, start1, pp1, pn1, d1, rd1;
    logic [7:0] rd_data1;
    logic [2:0] cnt1;
    logic       rd_valid1, busy1, perr1, ferr1, terr1, ovf1;

    logic       wait2, start2, pp2, pn2, d2, rd2;
    logic [8:0] rd_data2;
    logic [2:0] cnt2;
    logic       rd_valid2, busy2, perr2, ferr2, terr2, ovf2;

    int compared   = 0;
    int mismatched = 0;
    int perr_n = 0, ferr_n = 0, terr_n = 0, ovf_n = 0, err2_n = 0;

    ps2_rx_framed #(
        .DATA_BITS(8), .PARITY_EN(1), .ODD_PARITY(1), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(100)
    ) dut1 (
        .clk(clk), .reset(reset),
        .wait_for_incoming_data(wait1), .start_receiving_data(start1),
        .ps2_clk_posedge(pp1), .ps2_clk_negedge(pn1), .ps2_data(d1), .rd_en(rd1),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .fifo_count(cnt1), .busy(busy1),
        .parity_err(perr1), .frame_err(ferr1), .timeout_err(terr1), .overflow(ovf1)
    );

    ps2_rx_framed #(
        .DATA_BITS(9), .PARITY_EN(0), .ODD_PARITY(1), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(100000)
    ) dut2 (
        .clk(clk), .reset(reset),
        .wait_for_incoming_data(wait2), .start_receiving_data(start2),
        .ps2_clk_posedge(pp2), .ps2_clk_negedge(pn2), .ps2_data(d2), .rd_en(rd2),
        .rd_data(rd_data2), .rd_valid(rd_valid2), .fifo_count(cnt2), .busy(busy2),
        .parity_err(perr2), .frame_err(ferr2), .timeout_err(terr2), .overflow(ovf2)
    );

    always @(negedge clk) begin
        if (perr1) perr_n++;
        if (ferr1) ferr_n++;
        if (terr1) terr_n++;
        if (ovf1)  ovf_n++;
        if (perr2 || ferr2 || terr2 || ovf2) err2_n++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_bit(input bit which, input logic b, input logic pop_at);
        if (!which) begin d1 = b; pn1 = 1'b1; end
        else        begin d2 = b; pn2 = 1'b1; end
        tick();
        pn1 = 1'b0; pn2 = 1'b0;
        tick();
        if (!which) begin pp1 = 1'b1; rd1 = pop_at; end
        else        pp2 = 1'b1;
        tick();
        pp1 = 1'b0; pp2 = 1'b0; rd1 = 1'b0;
        tick();
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par_flip,
                              input logic stop_bit, input logic pop_at_stop);
        wait1 = 1'b1;
        tick();
        send_bit(0, 1'b0, 1'b0);
        wait1 = 1'b0;
        for (int i = 0; i < 8; i++) send_bit(0, data[i], 1'b0);
        send_bit(0, (~(^data)) ^ par_flip, 1'b0);
        send_bit(0, stop_bit, pop_at_stop);
        tick();
    endtask

    task automatic test_reset();
        compared++;
        if ({rd_valid1, cnt1, busy1, perr1, ferr1, terr1, ovf1, rd_data1} !== 16'h0) begin
            mismatched++;
            $display("FAIL reset_outputs: got v=%0b c=%0d b=%0b d=%h want all 0",
                     rd_valid1, cnt1, busy1, rd_data1);
        end
        compared++;
        if ({rd_valid2, cnt2, busy2} !== 5'h0) begin
            mismatched++;
            $display("FAIL reset_outputs2: got v=%0b c=%0d b=%0b want 0", rd_valid2, cnt2, busy2);
        end
    endtask

    task automatic test_good_frame();
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        compared++;
        if (rd_valid1 !== 1'b1) begin
            mismatched++; $display("FAIL good_rd_valid: got %0b want 1", rd_valid1);
        end
        compared++;
        if (rd_data1 !== 8'h1C) begin
            mismatched++; $display("FAIL good_rd_data: got %h want 1c", rd_data1);
        end
        compared++;
        if (cnt1 !== 3'd1) begin
            mismatched++; $display("FAIL good_count: got %0d want 1", cnt1);
        end
        compared++;
        if (perr_n + ferr_n + terr_n + ovf_n !== 0) begin
            mismatched++; $display("FAIL good_no_pulses: got %0d pulses want 0",
                                   perr_n + ferr_n + terr_n + ovf_n);
        end
        rd1 = 1'b1; tick(); rd1 = 1'b0;
        compared++;
        if (cnt1 !== 3'd0 || rd_valid1 !== 1'b0) begin
            mismatched++; $display("FAIL good_pop: got c=%0d v=%0b want 0 0", cnt1, rd_valid1);
        end
        rd1 = 1'b1; tick(); rd1 = 1'b0;
        compared++;
        if (cnt1 !== 3'd0) begin
            mismatched++; $display("FAIL pop_empty: got c=%0d want 0", cnt1);
        end
    endtask

    task automatic test_parity_err();
        send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
        compared++;
        if (perr_n !== 1 || ferr_n !== 0) begin
            mismatched++; $display("FAIL parity_pulse: got p=%0d f=%0d want 1 0", perr_n, ferr_n);
        end
        compared++;
        if (cnt1 !== 3'd0 || busy1 !== 1'b0) begin
            mismatched++; $display("FAIL parity_drop: got c=%0d b=%0b want 0 0", cnt1, busy1);
        end
    endtask

    task automatic test_frame_err();
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        compared++;
        if (ferr_n !== 1 || perr_n !== 1 || cnt1 !== 3'd0) begin
            mismatched++;
            $display("FAIL frame_err: got f=%0d p=%0d c=%0d want 1 1 0", ferr_n, perr_n, cnt1);
        end
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        compared++;
        if (cnt1 !== 3'd1 || rd_data1 !== 8'h5A) begin
            mismatched++; $display("FAIL frame_retry: got c=%0d d=%h want 1 5a", cnt1, rd_data1);
        end
        rd1 = 1'b1; tick(); rd1 = 1'b0;
    endtask

    task automatic test_overflow();
        logic [7:0] exp [4];
        exp = '{8'h01, 8'h02, 8'h03, 8'h04};
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0);
        compared++;
        if (cnt1 !== 3'd4 || ovf_n !== 1) begin
            mismatched++; $display("FAIL overflow: got c=%0d ovf=%0d want 4 1", cnt1, ovf_n);
        end
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (rd_data1 !== exp[i]) begin
                mismatched++; $display("FAIL overflow_pop%0d: got %h want %h", i, rd_data1, exp[i]);
            end
            rd1 = 1'b1; tick(); rd1 = 1'b0;
        end
        compared++;
        if (cnt1 !== 3'd0 || rd_valid1 !== 1'b0) begin
            mismatched++; $display("FAIL overflow_drain: got c=%0d v=%0b want 0 0", cnt1, rd_valid1);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [4];
        exp = '{8'h11, 8'h12, 8'h13, 8'h14};
        for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b1, 1'b0);
        send_frame(8'h14, 1'b0, 1'b1, 1'b1);
        compared++;
        if (cnt1 !== 3'd4 || ovf_n !== 1) begin
            mismatched++; $display("FAIL full_push_pop: got c=%0d ovf=%0d want 4 1", cnt1, ovf_n);
        end
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (rd_data1 !== exp[i]) begin
                mismatched++; $display("FAIL b2b_pop%0d: got %h want %h", i, rd_data1, exp[i]);
            end
            rd1 = 1'b1; tick(); rd1 = 1'b0;
        end
    endtask

    task automatic test_timeout();
        int n;
        wait1 = 1'b1;
        tick();
        send_bit(0, 1'b0, 1'b0);
        wait1 = 1'b0;
        for (int i = 0; i < 3; i++) send_bit(0, 1'b1, 1'b0);
        compared++;
        if (busy1 !== 1'b1) begin
            mismatched++; $display("FAIL timeout_busy: got %0b want 1", busy1);
        end
        n = 1;
        while (terr1 !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        compared++;
        if (n !== 100) begin
            mismatched++; $display("FAIL timeout_cycle: got %0d want 100", n);
        end
        compared++;
        if (busy1 !== 1'b0 || cnt1 !== 3'd0) begin
            mismatched++; $display("FAIL timeout_abort: got b=%0b c=%0d want 0 0", busy1, cnt1);
        end
        tick();
        compared++;
        if (terr_n !== 1) begin
            mismatched++; $display("FAIL timeout_once: got %0d want 1", terr_n);
        end
    endtask

    task automatic test_reset_mid_frame();
        int pulses;
        send_frame(8'h21, 1'b0, 1'b1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0);
        compared++;
        if (cnt1 !== 3'd2) begin
            mismatched++; $display("FAIL pre_reset_count: got %0d want 2", cnt1);
        end
        wait1 = 1'b1;
        tick();
        send_bit(0, 1'b0, 1'b0);
        wait1 = 1'b0;
        for (int i = 0; i < 3; i++) send_bit(0, 1'b0, 1'b0);
        pulses = perr_n + ferr_n + terr_n + ovf_n;
        reset = 1'b0;
        #1;
        compared++;
        if (rd_valid1 !== 1'b0 || cnt1 !== 3'd0 || busy1 !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid: got v=%0b c=%0d b=%0b want 0 0 0", rd_valid1, cnt1, busy1);
        end
        tick();
        reset = 1'b1;
        repeat (3) tick();
        compared++;
        if (perr_n + ferr_n + terr_n + ovf_n !== pulses || busy1 !== 1'b0) begin
            mismatched++; $display("FAIL reset_no_pulse: got %0d pulses b=%0b want %0d 0",
                                   perr_n + ferr_n + terr_n + ovf_n, busy1, pulses);
        end
    endtask

    task automatic test_nine_bit();
        logic [8:0] word;
        word = 9'h1A5;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int i = 0; i < 9; i++) send_bit(1, word[i], 1'b0);
        send_bit(1, 1'b1, 1'b0);
        tick();
        compared++;
        if (rd_valid2 !== 1'b1 || rd_data2 !== 9'h1A5 || cnt2 !== 3'd1) begin
            mismatched++; $display("FAIL nine_bit: got v=%0b d=%h c=%0d want 1 1a5 1",
                                   rd_valid2, rd_data2, cnt2);
        end
        compared++;
        if (err2_n !== 0) begin
            mismatched++; $display("FAIL nine_bit_pulses: got %0d want 0", err2_n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        wait1 = 1'b0; start1 = 1'b0; pp1 = 1'b0; pn1 = 1'b0; d1 = 1'b1; rd1 = 1'b0;
        wait2 = 1'b0; start2 = 1'b0; pp2 = 1'b0; pn2 = 1'b0; d2 = 1'b1; rd2 = 1'b0;
        repeat (3) tick();
        test_reset();
        reset = 1'b1;
        tick();
        test_reset();
        test_good_frame();
        test_parity_err();
        test_frame_err();
        test_overflow();
        test_back_to_back();
        test_timeout();
        test_reset_mid_frame();
        test_nine_bit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
